store_access_ctrl: RTL and testbench

//  Sequencer directly upstream of the memory tanks: turns one parallel read/write

---
 rtl/edsac_store_pkg.sv | 28 ++
 rtl/circulation_counter.sv | 55 +++++
 rtl/store_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_store_access_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_store_pkg.sv
`default_nettype none
// ============================================================================
// edsac_store_pkg : store-rack constants, access FSM state, {tank, word} address
// Revision 1.0
// ============================================================================
package edsac_store_pkg;

  localparam int STORE_LEN  = 16;
  localparam int WORD_WIDTH = 36;
  localparam int NUM_TANKS  = 32;
  localparam int TANK_AW    = $clog2(NUM_TANKS);
  localparam int WORD_AW    = $clog2(STORE_LEN);
  localparam int BIT_AW     = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } store_state_e;

  typedef struct packed {
    logic [TANK_AW-1:0] tank;
    logic [WORD_AW-1:0] word;
  } store_addr_t;

endpackage
`default_nettype wire

// File: rtl/circulation_counter.sv
`default_nettype none
// ============================================================================
// circulation_counter : bit/word position within one tank circulation
// Revision 1.0
// ============================================================================
module circulation_counter #(
  parameter int WORD_WIDTH = edsac_store_pkg::WORD_WIDTH,
  parameter int STORE_LEN  = edsac_store_pkg::STORE_LEN,
  parameter int POS_AW     = $clog2(WORD_WIDTH),
  parameter int WORD_AW    = $clog2(STORE_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [POS_AW-1:0]  o_bit_pos,
  output logic [WORD_AW-1:0] o_word_pos,
  output logic [WORD_AW-1:0] o_next_word_pos,
  output logic               o_slot_start
);

  logic [POS_AW-1:0]  r_bit;
  logic [WORD_AW-1:0] r_word;
  logic [POS_AW-1:0]  w_next_bit;
  logic [WORD_AW-1:0] w_next_word;
  logic               w_bit_wrap;
  logic               w_word_wrap;

  assign w_bit_wrap  = (r_bit == POS_AW'(WORD_WIDTH - 1));
  assign w_word_wrap = (r_word == WORD_AW'(STORE_LEN - 1));

  always_comb begin
    w_next_bit  = w_bit_wrap ? '0 : r_bit + POS_AW'(1);
    w_next_word = r_word;
    if (w_bit_wrap) begin
      w_next_word = w_word_wrap ? '0 : r_word + WORD_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit  <= '0;
      r_word <= '0;
    end else begin
      r_bit  <= w_next_bit;
      r_word <= w_next_word;
    end
  end

  // High on the last bit of a word: the coming edge opens the next word slot.
  assign o_slot_start    = w_bit_wrap;
  assign o_bit_pos       = r_bit;
  assign o_word_pos      = r_word;
  assign o_next_word_pos = w_next_word;

endmodule
`default_nettype wire

// File: rtl/store_access_ctrl.sv
`default_nettype none
// ============================================================================
// store_access_ctrl : serialises one parallel tank read/write into tank gating
// Revision 1.0
// ============================================================================
module store_access_ctrl #(
  parameter int STORE_LEN  = edsac_store_pkg::STORE_LEN,
  parameter int WORD_WIDTH = edsac_store_pkg::WORD_WIDTH,
  parameter int NUM_TANKS  = edsac_store_pkg::NUM_TANKS,
  parameter int TANK_AW    = edsac_store_pkg::TANK_AW,
  parameter int WORD_AW    = edsac_store_pkg::WORD_AW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          we,
  input  logic [TANK_AW+WORD_AW-1:0]    addr,
  input  logic [WORD_WIDTH-1:0]         wdata,
  output logic [WORD_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(WORD_WIDTH)-1:0] bit_pos,
  output logic [WORD_AW-1:0]            word_pos,
  output logic                          rack_mib,
  output logic [NUM_TANKS-1:0]          rack_loc_t_in,
  output logic [NUM_TANKS-1:0]          rack_loc_t_clr,
  output logic [NUM_TANKS-1:0]          rack_loc_t_out,
  input  logic                          rack_loc_mob_t
);

  import edsac_store_pkg::*;

  localparam int POS_AW = $clog2(WORD_WIDTH);

  store_state_e r_state;
  store_state_e w_state_nxt;

  logic                  r_we;
  logic                  r_err;
  logic [TANK_AW-1:0]    r_tank;
  logic [WORD_AW-1:0]    r_word;
  logic [WORD_WIDTH-1:0] r_sreg;
  logic [WORD_WIDTH-1:0] r_rdata;
  logic [NUM_TANKS-1:0]  r_t_in;
  logic [NUM_TANKS-1:0]  r_t_clr;
  logic [NUM_TANKS-1:0]  r_t_out;

  logic [NUM_TANKS-1:0]  w_sel;
  logic [TANK_AW-1:0]    w_req_tank;
  logic [WORD_AW-1:0]    w_req_word;
  logic [POS_AW-1:0]     w_bit_pos;
  logic [WORD_AW-1:0]    w_word_pos;
  logic [WORD_AW-1:0]    w_next_word;
  logic                  w_slot_start;
  logic                  w_tank_ok;
  logic                  w_accept;
  logic                  w_at_slot;
  logic [WORD_WIDTH-1:0] w_shift_in;

  circulation_counter #(
    .WORD_WIDTH (WORD_WIDTH),
    .STORE_LEN  (STORE_LEN),
    .POS_AW     (POS_AW),
    .WORD_AW    (WORD_AW)
  ) u_circ (
    .clk             (clk),
    .rst             (rst),
    .o_bit_pos       (w_bit_pos),
    .o_word_pos      (w_word_pos),
    .o_next_word_pos (w_next_word),
    .o_slot_start    (w_slot_start)
  );

  assign w_req_tank = addr[WORD_AW +: TANK_AW];
  assign w_req_word = addr[WORD_AW-1:0];
  assign w_tank_ok  = (32'(w_req_tank) < 32'(NUM_TANKS));
  assign w_accept   = (r_state == ST_IDLE) && req;
  // Next edge lands on bit 0 of the addressed word.
  assign w_at_slot  = w_slot_start && (w_next_word == r_word);
  assign w_shift_in = {rack_loc_mob_t, r_sreg[WORD_WIDTH-1:1]};

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      if (r_tank == TANK_AW'(i)) begin
        w_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req)          w_state_nxt = w_tank_ok ? ST_WAIT : ST_DONE;
      ST_WAIT: if (w_at_slot)    w_state_nxt = ST_XFER;
      ST_XFER: if (w_slot_start) w_state_nxt = ST_DONE;
      ST_DONE:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_tank  <= '0;
      r_word  <= '0;
      r_sreg  <= '0;
      r_rdata <= '0;
      r_t_in  <= '0;
      r_t_clr <= '0;
      r_t_out <= '0;
    end else begin
      if (w_accept) begin
        r_we   <= we;
        r_tank <= w_req_tank;
        r_word <= w_req_word;
        r_err  <= !w_tank_ok;
        r_sreg <= wdata;
      end else if (r_state == ST_XFER) begin
        if (r_we) begin
          r_sreg <= r_sreg >> 1;
        end else begin
          r_sreg <= w_shift_in;
          if (w_slot_start) begin
            r_rdata <= w_shift_in;
          end
        end
      end

      // Gates are registered off the next state so they line up with bit 0.
      if (w_state_nxt == ST_XFER) begin
        r_t_in  <= r_we ? w_sel : '0;
        r_t_clr <= r_we ? w_sel : '0;
        r_t_out <= r_we ? '0 : w_sel;
      end else begin
        r_t_in  <= '0;
        r_t_clr <= '0;
        r_t_out <= '0;
      end
    end
  end

  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign err            = (r_state == ST_DONE) && r_err;
  assign rdata          = r_rdata;
  assign bit_pos        = w_bit_pos;
  assign word_pos       = w_word_pos;
  assign rack_mib       = (r_state == ST_XFER) && r_we && r_sreg[0];
  assign rack_loc_t_in  = r_t_in;
  assign rack_loc_t_clr = r_t_clr;
  assign rack_loc_t_out = r_t_out;

endmodule
`default_nettype wire

// File: tb/tb_store_access_ctrl.sv
`default_nettype none
// tb_store_access_ctrl : random and directed accesses against a behavioural
// tank rack and a transaction-level word memory.
module tb_store_access_ctrl;

  import edsac_store_pkg::*;

  localparam int POSN = STORE_LEN * WORD_WIDTH;
  localparam int NT2  = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst, req, we, busy, done, err, rack_mib, mob;
  logic [TANK_AW+WORD_AW-1:0] addr;
  logic [WORD_WIDTH-1:0]      wdata, rdata;
  logic [BIT_AW-1:0]          bit_pos;
  logic [WORD_AW-1:0]         word_pos;
  logic [NUM_TANKS-1:0]       t_in, t_clr, t_out;

  logic                       req2, we2, busy2, done2, err2, mib2, mob2;
  logic [TANK_AW+WORD_AW-1:0] addr2;
  logic [WORD_WIDTH-1:0]      wdata2, rdata2;
  logic [BIT_AW-1:0]          bit_pos2;
  logic [WORD_AW-1:0]         word_pos2;
  logic [NT2-1:0]             t_in2, t_clr2, t_out2;

  store_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .bit_pos(bit_pos),
    .word_pos(word_pos), .rack_mib(rack_mib), .rack_loc_t_in(t_in),
    .rack_loc_t_clr(t_clr), .rack_loc_t_out(t_out), .rack_loc_mob_t(mob)
  );

  store_access_ctrl #(.NUM_TANKS(NT2)) dut24 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .busy(busy2), .done(done2), .err(err2), .bit_pos(bit_pos2),
    .word_pos(word_pos2), .rack_mib(mib2), .rack_loc_t_in(t_in2),
    .rack_loc_t_clr(t_clr2), .rack_loc_t_out(t_out2), .rack_loc_mob_t(mob2)
  );

  // Behavioural tank rack: position index 0..POSN-1 realigned by rst.
  logic [WORD_WIDTH-1:0] tank_mem [NUM_TANKS][STORE_LEN];
  logic [WORD_WIDTH-1:0] ref_mem  [NUM_TANKS][STORE_LEN];
  int tb_idx = 0;
  int cyc    = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tb_idx <= rst ? 0 : (tb_idx + 1) % POSN;
    for (int k = 0; k < NUM_TANKS; k++) begin
      if (t_in[k] && t_clr[k]) tank_mem[k][tb_idx / WORD_WIDTH][tb_idx % WORD_WIDTH] = rack_mib;
    end
  end

  always_comb begin
    mob = 1'b0;
    for (int k = 0; k < NUM_TANKS; k++) begin
      if (t_out[k]) mob = tank_mem[k][tb_idx / WORD_WIDTH][tb_idx % WORD_WIDTH];
    end
  end

  typedef struct {
    bit                    we;
    logic [WORD_WIDTH-1:0] data;
    int                    done_cyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int gate_viol = 0;
  bit gate2_seen = 1'b0;
  logic [WORD_WIDTH-1:0] exp_last;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [TANK_AW+WORD_AW-1:0] mk_addr(input int tank, input int word);
    store_addr_t a;
    a.tank = TANK_AW'(tank);
    a.word = WORD_AW'(word);
    return a;
  endfunction

  // Expected response of an access accepted at edge acc_cyc, req sampled at position p.
  task automatic push_entry(input bit w, input int tank, input int word,
                            input logic [WORD_WIDTH-1:0] d, input int p, input int acc_cyc);
    exp_t e;
    int   wt;
    wt = ((word * WORD_WIDTH - p - 2) % POSN + POSN) % POSN + 1;
    if (w) begin
      ref_mem[tank][word] = d;
      e.data = exp_last;
    end else begin
      e.data   = ref_mem[tank][word];
      exp_last = e.data;
    end
    e.we       = w;
    e.done_cyc = acc_cyc + wt + WORD_WIDTH;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input bit w, input int tank, input int word,
                       input logic [WORD_WIDTH-1:0] d, input bit track, input bit hold);
    wait_idle();
    we    = w;
    addr  = mk_addr(tank, word);
    wdata = d;
    req   = 1'b1;
    if (track) push_entry(w, tank, word, d, tb_idx, cyc + 1);
    @(negedge clk);
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    wait_idle();
    while (tb_idx != target && n < POSN + 2) begin
      @(negedge clk);
      n++;
    end
    check("pos_reached", 64'(tb_idx), 64'(target));
  endtask

  // Scoreboard monitor and gate invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((t_in != t_clr) || ((t_in & t_out) != '0) || ($countones(t_in | t_out) > 1) ||
          (!busy && ((t_in | t_out | t_clr) != '0)))
        gate_viol++;
      if ((t_in2 | t_clr2 | t_out2) != '0) gate2_seen = 1'b1;
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check(e.we ? "rdata_held" : "rdata_read", 64'(rdata), 64'(e.data));
          check("err_clear", 64'(err), 64'd0);
          check("busy_at_done", 64'(busy), 64'd1);
          check("bit_pos", 64'(bit_pos), 64'(tb_idx % WORD_WIDTH));
          check("word_pos", 64'(word_pos), 64'(tb_idx / WORD_WIDTH));
        end
      end
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [WORD_WIDTH-1:0] v;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; mob2 = 1'b0;
    exp_last = '0;
    for (int t = 0; t < NUM_TANKS; t++) begin
      for (int w = 0; w < STORE_LEN; w++) begin
        v = WORD_WIDTH'({$urandom(), $urandom()});
        tank_mem[t][w] = v;
        ref_mem[t][w]  = v;
      end
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_bit_pos", 64'(bit_pos), 64'd0);
    check("rst_word_pos", 64'(word_pos), 64'd0);
    check("rst_gates", 64'(t_in | t_clr | t_out), 64'd0);
    check("rst_mib", 64'(rack_mib), 64'd0);
    rst = 1'b0;

    // Tank 30 on a 24-tank controller: immediate done with err.
    req2  = 1'b1;
    addr2 = mk_addr(30, 4);
    @(negedge clk);
    req2 = 1'b0;
    check("err_done", 64'(done2), 64'd1);
    check("err_flag", 64'(err2), 64'd1);
    @(negedge clk);
    check("err_done_pulse", 64'(done2), 64'd0);
    check("err_busy_clear", 64'(busy2), 64'd0);

    // Write then read back, neighbours untouched.
    issue(1'b1, 3, 5, 36'h9ABCD1234, 1'b1, 1'b0);
    issue(1'b0, 3, 5, '0, 1'b1, 1'b0);
    issue(1'b0, 3, 4, '0, 1'b1, 1'b0);
    issue(1'b0, 3, 6, '0, 1'b1, 1'b0);

    // Accepted at (0,0) for word 0: 575 wait cycles; then 15 and 0 across the wrap.
    wait_pos(0);
    issue(1'b0, 9, 0, '0, 1'b1, 1'b0);
    issue(1'b0, 9, 15, '0, 1'b1, 1'b0);
    issue(1'b0, 9, 0, '0, 1'b1, 1'b0);

    // Minimum wait: XFER on the edge after the single WAIT cycle.
    wait_pos(7 * WORD_WIDTH - 2);
    issue(1'b0, 12, 7, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("xfer_start", 64'(t_out[12]), 64'd1);

    // Reset at bit 20 of an all-ones write over zero.
    wait_idle();
    tank_mem[7][2] = '0;
    issue(1'b1, 7, 2, {WORD_WIDTH{1'b1}}, 1'b0, 1'b0);
    n = 0;
    while (!(t_in[7] && (tb_idx % WORD_WIDTH) == 20) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rst_bit20_reached", 64'(t_in[7]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_gates", 64'(t_in | t_clr | t_out), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    rst = 1'b0;
    exp_last       = '0;
    ref_mem[7][2]  = 36'h0001FFFFF;
    repeat (60) @(negedge clk);
    issue(1'b0, 7, 2, '0, 1'b1, 1'b0);

    // req held through busy: one transfer, the next accepted in the IDLE cycle after done.
    issue(1'b0, 3, 5, '0, 1'b1, 1'b1);
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("hold_done_seen", 64'(done), 64'd1);
    push_entry(1'b0, 3, 5, '0, (tb_idx + 1) % POSN, cyc + 2);
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int t, w;
      if ($urandom_range(2, 0) == 0) begin
        t = $urandom_range(NUM_TANKS - 1, 0);
        w = $urandom_range(STORE_LEN - 1, 0);
      end else begin
        t = 5;
        w = $urandom_range(3, 0);
      end
      issue(1'($urandom_range(1, 0)), t, w, WORD_WIDTH'({$urandom(), $urandom()}), 1'b1, 1'b0);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(40, 1)) @(negedge clk);
    end

    n = 0;
    while ((sbq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    check("gate_invariants", 64'(gate_viol), 64'd0);
    check("err_no_gates", 64'(gate2_seen), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
